// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte stream handshake feeding the UART transmitter
interface uart_transmitter_if;
  logic [7:0] transmit_data;
  logic       transmit_valid;
  logic       transmit_ready;

  modport master (
    output transmit_data,
    output transmit_valid,
    input  transmit_ready
  );

  modport slave (
    input  transmit_data,
    input  transmit_valid,
    output transmit_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 serializer: start bit, eight data bits LSB first, one stop bit
module uart_transmitter #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115_200
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_transmitter_if.slave transmit,
  output logic              serial_out
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int COUNT_WIDTH    = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CYCLES_PER_BIT - 1);

  if (CYCLES_PER_BIT < 2) begin : g_bad_ratio
    $error("uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   line_q, line_d;
  logic                   ready_q, ready_d;
  logic                   handshake;
  logic                   baud_done;

  assign handshake      = transmit.transmit_valid && ready_q;
  assign baud_done      = (baud_q == LAST_COUNT);
  assign serial_out     = line_q;
  assign transmit.transmit_ready = ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (handshake) begin
          state_d = S_START;
          shift_d = transmit.transmit_data;
        end
      end

      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        // Ready is only high on the terminal stop cycle, so a handshake here chains frames with no gap.
        if (baud_done) begin
          baud_d = '0;
          if (handshake) begin
            state_d = S_START;
            shift_d = transmit.transmit_data;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so both leave flops with no extra cycle of latency.
    case (state_d)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE) || ((state_d == S_STOP) && (baud_d == LAST_COUNT));
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed and random checks of uart_transmitter
module tb_uart_transmitter;

  localparam int CB = 50_000_000 / 115_200;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic line_a, line_b;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [159:0] cap_line, cap_rdy;
  logic [7:0]   tx_q[$];
  logic [7:0]   rx_q[$];

  uart_transmitter_if if_a ();
  uart_transmitter_if if_b ();

  uart_transmitter #(.CLOCK_FREQUENCY(8), .BAUD_RATE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .transmit(if_a), .serial_out(line_a)
  );

  uart_transmitter dut_b (
    .clk(clk), .reset_n(reset_n), .transmit(if_b), .serial_out(line_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] frame80(input logic [7:0] b);
    logic [79:0] f;
    for (int k = 0; k < 80; k++) begin
      if (k < 8)       f[k] = 1'b0;
      else if (k < 72) f[k] = b[(k - 8) / 8];
      else             f[k] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [7:0] decode_at(input logic [159:0] v, input int base);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = v[base + 8 + 8 * i + 4];
    return d;
  endfunction

  // Returns at the first negedge after the handshake edge, valid still asserted.
  task automatic send_a(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    if_a.transmit_data  = b;
    if_a.transmit_valid = 1'b1;
    while (if_a.transmit_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("send_a_ready_wait", (waited < 200), 1'b1);
    @(negedge clk);
  endtask

  task automatic capture(input int n, input bit toggle_data, input int drop_valid_at);
    cap_line = '0;
    cap_rdy  = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_valid_at) if_a.transmit_valid = 1'b0;
      if (toggle_data) if_a.transmit_data = 8'($urandom);
      cap_line[i] = line_a;
      cap_rdy[i]  = if_a.transmit_ready;
    end
  endtask

  initial begin : rx_model
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && line_b === 1'b0) begin
        repeat (CB / 2) @(negedge clk);
        check("rx_start_bit", line_b, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CB) @(negedge clk);
          d[i] = line_b;
        end
        repeat (CB) @(negedge clk);
        check("rx_stop_bit", line_b, 1'b1);
        rx_q.push_back(d);
      end
    end
  end

  initial begin : watchdog
    #800_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] b;
    int         gap;
    int         waited;
    int         second_start;

    reset_n = 1'b0;
    if_a.transmit_data  = 8'h00;
    if_a.transmit_valid = 1'b0;
    if_b.transmit_data  = 8'h00;
    if_b.transmit_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_line_a", line_a, 1'b1);
    check("reset_ready_a", if_a.transmit_ready, 1'b0);
    check("reset_line_b", line_b, 1'b1);
    check("reset_ready_b", if_b.transmit_ready, 1'b0);
    reset_n = 1'b1;
    #1;
    check("ready_before_first_edge", if_a.transmit_ready, 1'b0);
    @(negedge clk);
    check("ready_first_edge", if_a.transmit_ready, 1'b1);

    // Single byte 0xA5
    send_a(8'hA5);
    capture(80, 1'b0, 0);
    check("a5_line", cap_line, frame80(8'hA5));
    check("a5_ready", cap_rdy, 160'd1 << 79);
    check("a5_decode", decode_at(cap_line, 0), 8'hA5);
    capture(20, 1'b0, -1);
    check("a5_after_line", cap_line, (160'd1 << 20) - 1);
    check("a5_after_ready", cap_rdy, (160'd1 << 20) - 1);

    // Idle with valid low
    capture(100, 1'b0, -1);
    check("idle_line", cap_line, (160'd1 << 100) - 1);
    check("idle_ready", cap_rdy, (160'd1 << 100) - 1);

    // Back-to-back 0x00 then 0xFF with valid held
    send_a(8'h00);
    if_a.transmit_data = 8'hFF;
    capture(160, 1'b0, 80);
    check("b2b_line", cap_line, {frame80(8'hFF), frame80(8'h00)});
    check("b2b_ready", cap_rdy, (160'd1 << 79) | (160'd1 << 159));
    check("b2b_decode0", decode_at(cap_line, 0), 8'h00);
    check("b2b_decode1", decode_at(cap_line, 80), 8'hFF);
    second_start = -1;
    for (int i = 159; i >= 72; i--) if (cap_line[i] == 1'b0) second_start = i;
    check("b2b_second_start", second_start, 80);

    // Data toggling mid-frame must not disturb the latched byte
    send_a(8'h5A);
    capture(80, 1'b1, 0);
    check("stable_line", cap_line, frame80(8'h5A));
    check("stable_decode", decode_at(cap_line, 0), 8'h5A);

    // Asynchronous reset in the middle of bit 0 of 0x3C
    send_a(8'h3C);
    capture(11, 1'b0, 0);
    check("pre_reset_line", cap_line[10], 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_line", line_a, 1'b1);
    check("async_reset_ready", if_a.transmit_ready, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rerelease_ready", if_a.transmit_ready, 1'b1);
    check("rerelease_line", line_a, 1'b1);
    send_a(8'h81);
    capture(80, 1'b0, 0);
    check("post_reset_line", cap_line, frame80(8'h81));
    check("post_reset_decode", decode_at(cap_line, 0), 8'h81);

    // Random bytes at default baud with random gaps, some back-to-back
    for (int k = 0; k < NB; k++) begin
      b   = 8'($urandom);
      gap = (k % 3 == 1) ? 0 : int'($urandom_range(0, 40));
      if_b.transmit_valid = 1'b0;
      repeat (gap) @(negedge clk);
      if_b.transmit_data  = b;
      if_b.transmit_valid = 1'b1;
      waited = 0;
      while (if_b.transmit_ready !== 1'b1 && waited < 10 * CB + 100) begin
        @(negedge clk);
        waited++;
      end
      check("send_b_ready_wait", (waited < 10 * CB + 100), 1'b1);
      @(negedge clk);
      if_b.transmit_valid = 1'b0;
      tx_q.push_back(b);
    end
    waited = 0;
    while (rx_q.size() < NB && waited < 12 * CB) begin
      @(negedge clk);
      waited++;
    end
    check("rx_count", rx_q.size(), NB);
    for (int k = 0; k < NB && k < rx_q.size(); k++) check("rx_byte", rx_q[k], tx_q[k]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
